// File: rtl/equilibrium_maxxing_uc.sv
// Game control unit: sequences calibration, level selection, the preparation
// countdown and RODADAS rounds of target/fade/balance/score for the datapath.
module equilibrium_maxxing_uc #(
  parameter int RODADAS  = 10,
  parameter int T_JOGADA = 250_000_000,
  parameter int T_CALIB  = 500_000_000
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       iniciar,
  input  logic       end_left,
  input  logic       end_right,
  input  logic       prep_done,
  input  logic       ganhou_ponto,
  input  logic       perdeu_ponto,
  output logic       calib,
  output logic       trava_servo,
  output logic       start_game,
  output logic       reset_nivel_locked,
  output logic       reset_nivel,
  output logic       reset_prep_cnt,
  output logic       gerar_nova_jogada,
  output logic       fade_trigger,
  output logic       conta_nivel,
  output logic       pronto,
  output logic       erro_calib,
  output logic [7:0] rodada,
  output logic [3:0] db_estado
);

  typedef enum logic [3:0] {
    INICIAL    = 4'd0,
    CALIBRA    = 4'd1,
    ESCOLHE    = 4'd2,
    TRAVA      = 4'd3,
    PREPARA    = 4'd4,
    GERA       = 4'd5,
    FADE       = 4'd6,
    JOGANDO    = 4'd7,
    ACERTO     = 4'd8,
    FALHA      = 4'd9,
    PROXIMA    = 4'd10,
    FIM        = 4'd11,
    ERRO_CALIB = 4'd12
  } state_t;

  localparam int JW = (T_JOGADA > 1) ? $clog2(T_JOGADA) : 1;
  localparam int CW = (T_CALIB > 1) ? $clog2(T_CALIB) : 1;
  localparam logic [JW-1:0] JOG_LAST  = JW'(T_JOGADA - 1);
  localparam logic [CW-1:0] CAL_LAST  = CW'(T_CALIB - 1);
  localparam logic [7:0]    RODADAS_L = 8'(RODADAS);

  state_t        state;
  logic [JW-1:0] t_jog;
  logic [CW-1:0] t_cal;
  logic          iniciar_d;
  logic          ini_ed;

  assign ini_ed    = iniciar & ~iniciar_d;
  assign db_estado = state;

  // NOTE: state is updated with non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state     <= INICIAL;
      rodada    <= '0;
      t_jog     <= '0;
      t_cal     <= '0;
      iniciar_d <= 1'b0;
    end else begin
      iniciar_d <= iniciar;
      case (state)
        INICIAL: begin
          rodada <= '0;
          if (ini_ed) begin
            t_cal <= '0;
            state <= CALIBRA;
          end
        end
        CALIBRA: begin
          t_cal <= t_cal + CW'(1);
          if (end_left | end_right)  state <= ESCOLHE;
          else if (t_cal == CAL_LAST) state <= ERRO_CALIB;
        end
        ESCOLHE: if (ini_ed) state <= TRAVA;
        TRAVA:   state <= PREPARA;
        PREPARA: if (prep_done) state <= GERA;
        GERA: begin
          t_jog <= '0;
          state <= FADE;
        end
        FADE: state <= JOGANDO;
        JOGANDO: begin
          t_jog <= t_jog + JW'(1);
          // A win reported together with a loss counts as a win.
          if (ganhou_ponto)                            state <= ACERTO;
          else if (perdeu_ponto || t_jog == JOG_LAST)  state <= FALHA;
        end
        ACERTO, FALHA: begin
          if (rodada != 8'hFF) rodada <= rodada + 8'd1;
          state <= PROXIMA;
        end
        PROXIMA: state <= (rodada == RODADAS_L) ? FIM : GERA;
        FIM, ERRO_CALIB: if (ini_ed) state <= INICIAL;
        default: state <= INICIAL;
      endcase
    end
  end

  // Moore decode straight from the state register, so an asynchronous reset
  // drops every strobe in the same cycle.
  // NOTE: every output gets a default before the case so no latch is inferred.
  always_comb begin
    calib              = 1'b0;
    trava_servo        = 1'b0;
    start_game         = 1'b0;
    reset_nivel_locked = 1'b0;
    reset_nivel        = 1'b0;
    reset_prep_cnt     = 1'b0;
    gerar_nova_jogada  = 1'b0;
    fade_trigger       = 1'b0;
    conta_nivel        = 1'b0;
    pronto             = 1'b0;
    erro_calib         = 1'b0;
    case (state)
      INICIAL: begin
        reset_nivel        = 1'b1;
        reset_nivel_locked = 1'b1;
        reset_prep_cnt     = 1'b1;
      end
      CALIBRA: calib = 1'b1;
      TRAVA: begin
        start_game     = 1'b1;
        reset_prep_cnt = 1'b1;
      end
      PREPARA: trava_servo       = 1'b1;
      GERA:    gerar_nova_jogada = 1'b1;
      FADE:    fade_trigger      = 1'b1;
      ACERTO:  conta_nivel       = 1'b1;
      FIM: begin
        pronto      = 1'b1;
        trava_servo = 1'b1;
      end
      ERRO_CALIB: begin
        erro_calib  = 1'b1;
        trava_servo = 1'b1;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_equilibrium_maxxing_uc.sv
// Self-checking bench for equilibrium_maxxing_uc: per-cycle expectations are
// queued as stimulus is driven and compared on the falling clock edge.
module tb_equilibrium_maxxing_uc;

  localparam int RODADAS  = 3;
  localparam int T_JOGADA = 16;
  localparam int T_CALIB  = 24;

  localparam logic [3:0] S_INI = 4'd0,  S_CAL = 4'd1,  S_ESC = 4'd2,  S_TRV = 4'd3;
  localparam logic [3:0] S_PRE = 4'd4,  S_GER = 4'd5,  S_FAD = 4'd6,  S_JOG = 4'd7;
  localparam logic [3:0] S_ACE = 4'd8,  S_FAL = 4'd9,  S_PRX = 4'd10, S_FIM = 4'd11;
  localparam logic [3:0] S_ERR = 4'd12;

  // Input vector order: {iniciar, end_left, end_right, prep_done, ganhou, perdeu}
  localparam logic [5:0] I_NONE = 6'b000000, I_INI = 6'b100000, I_EL = 6'b010000;
  localparam logic [5:0] I_ER   = 6'b001000, I_PD  = 6'b000100, I_GP = 6'b000010;
  localparam logic [5:0] I_PP   = 6'b000001;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       iniciar = 1'b0, end_left = 1'b0, end_right = 1'b0, prep_done = 1'b0;
  logic       ganhou_ponto = 1'b0, perdeu_ponto = 1'b0;
  logic       calib, trava_servo, start_game, reset_nivel_locked, reset_nivel;
  logic       reset_prep_cnt, gerar_nova_jogada, fade_trigger, conta_nivel;
  logic       pronto, erro_calib;
  logic [7:0] rodada;
  logic [3:0] db_estado;
  logic [10:0] outs_v;

  typedef struct {
    string       tag;
    logic [3:0]  st;
    logic [10:0] outs;
    logic [7:0]  rod;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int   n_cmp = 0;
  int   n_err = 0;
  int   n_conta = 0;

  always #5 clock = ~clock;

  equilibrium_maxxing_uc #(
    .RODADAS (RODADAS),
    .T_JOGADA(T_JOGADA),
    .T_CALIB (T_CALIB)
  ) dut (
    .clock             (clock),
    .reset             (reset),
    .iniciar           (iniciar),
    .end_left          (end_left),
    .end_right         (end_right),
    .prep_done         (prep_done),
    .ganhou_ponto      (ganhou_ponto),
    .perdeu_ponto      (perdeu_ponto),
    .calib             (calib),
    .trava_servo       (trava_servo),
    .start_game        (start_game),
    .reset_nivel_locked(reset_nivel_locked),
    .reset_nivel       (reset_nivel),
    .reset_prep_cnt    (reset_prep_cnt),
    .gerar_nova_jogada (gerar_nova_jogada),
    .fade_trigger      (fade_trigger),
    .conta_nivel       (conta_nivel),
    .pronto            (pronto),
    .erro_calib        (erro_calib),
    .rodada            (rodada),
    .db_estado         (db_estado)
  );

  assign outs_v = {calib, trava_servo, start_game, reset_nivel_locked, reset_nivel,
                   reset_prep_cnt, gerar_nova_jogada, fade_trigger, conta_nivel,
                   pronto, erro_calib};

  // Output bits asserted in each state, same bit order as outs_v.
  function automatic logic [10:0] exp_outs(input logic [3:0] s);
    case (s)
      4'd0:    return 11'b00011100000;
      4'd1:    return 11'b10000000000;
      4'd3:    return 11'b00100100000;
      4'd4:    return 11'b01000000000;
      4'd5:    return 11'b00000010000;
      4'd6:    return 11'b00000001000;
      4'd8:    return 11'b00000000100;
      4'd11:   return 11'b01000000010;
      4'd12:   return 11'b01000000001;
      default: return 11'b00000000000;
    endcase
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", tag, got, got, exp, exp);
    end
  endtask

  // One clock cycle: apply inputs just after the edge and queue what the DUT
  // must show during this cycle.
  task automatic cyc(input string tag, input logic [5:0] in_v,
                     input logic [3:0] st, input logic [7:0] rod);
    exp_t e;
    @(posedge clock);
    #1;
    {iniciar, end_left, end_right, prep_done, ganhou_ponto, perdeu_ponto} = in_v;
    e.tag  = tag;
    e.st   = st;
    e.outs = exp_outs(st);
    e.rod  = rod;
    sb.push_back(e);
  endtask

  always @(negedge clock) begin
    if (sb.size() > 0) begin
      mon_e = sb.pop_front();
      check({mon_e.tag, "_st"},  32'(db_estado), 32'(mon_e.st));
      check({mon_e.tag, "_out"}, 32'(outs_v),    32'(mon_e.outs));
      check({mon_e.tag, "_rod"}, 32'(rodada),    32'(mon_e.rod));
    end
    if (conta_nivel) n_conta++;
  end

  initial begin
    // Reset, then a full game where every round is won.
    cyc("rst", I_NONE, S_INI, 8'd0);
    cyc("rst", I_NONE, S_INI, 8'd0);
    reset = 1'b0;
    cyc("idle",      I_NONE, S_INI, 8'd0);
    cyc("ini_press", I_INI,  S_INI, 8'd0);
    cyc("cal_hold",  I_INI,  S_CAL, 8'd0);
    for (int i = 0; i < 19; i++) cyc("cal_wait", I_NONE, S_CAL, 8'd0);
    cyc("cal_sw_r",  I_ER,   S_CAL, 8'd0);
    cyc("esc",       I_NONE, S_ESC, 8'd0);
    cyc("esc",       I_NONE, S_ESC, 8'd0);
    cyc("esc_go",    I_INI,  S_ESC, 8'd0);
    cyc("trava",     I_NONE, S_TRV, 8'd0);
    cyc("prep",      I_NONE, S_PRE, 8'd0);
    cyc("prep_ign",  I_GP | I_PP | I_INI, S_PRE, 8'd0);
    cyc("prep_done", I_PD,   S_PRE, 8'd0);
    for (int r = 0; r < RODADAS; r++) begin
      cyc("gera", I_NONE, S_GER, 8'(r));
      cyc("fade", I_NONE, S_FAD, 8'(r));
      if (r == 1) begin
        cyc("jog_both", I_GP | I_PP, S_JOG, 8'(r));
      end else begin
        cyc("jog",     I_NONE, S_JOG, 8'(r));
        cyc("jog_win", I_GP,   S_JOG, 8'(r));
      end
      cyc("acerto", I_NONE, S_ACE, 8'(r));
      cyc("prox",   I_NONE, S_PRX, 8'(r + 1));
    end
    cyc("fim", I_NONE, S_FIM, 8'd3);
    cyc("fim", I_NONE, S_FIM, 8'd3);
    @(negedge clock);
    #1;
    check("conta_pulses", 32'(n_conta), 32'd3);

    // Leave FIM, then hold iniciar: only one edge may be seen.
    cyc("fim_go",    I_INI,  S_FIM, 8'd3);
    cyc("ini_hold",  I_INI,  S_INI, 8'd3);
    cyc("ini_hold",  I_INI,  S_INI, 8'd0);
    cyc("ini_hold",  I_INI,  S_INI, 8'd0);
    cyc("ini_rel",   I_NONE, S_INI, 8'd0);
    cyc("ini_press", I_INI,  S_INI, 8'd0);

    // Second game: left switch, a lost round, a timed-out round, then reset.
    for (int i = 0; i < 3; i++) cyc("cal2", I_NONE, S_CAL, 8'd0);
    cyc("cal_sw_l",  I_EL,   S_CAL, 8'd0);
    cyc("esc_go",    I_INI,  S_ESC, 8'd0);
    cyc("trava",     I_NONE, S_TRV, 8'd0);
    cyc("prep_done", I_PD,   S_PRE, 8'd0);
    cyc("gera",      I_NONE, S_GER, 8'd0);
    cyc("fade",      I_NONE, S_FAD, 8'd0);
    cyc("jog_lose",  I_PP,   S_JOG, 8'd0);
    cyc("falha",     I_NONE, S_FAL, 8'd0);
    cyc("prox",      I_NONE, S_PRX, 8'd1);
    cyc("gera",      I_NONE, S_GER, 8'd1);
    cyc("fade",      I_NONE, S_FAD, 8'd1);
    for (int i = 0; i < T_JOGADA; i++) cyc("jog_tmo", I_NONE, S_JOG, 8'd1);
    cyc("falha_tmo", I_NONE, S_FAL, 8'd1);
    cyc("prox",      I_NONE, S_PRX, 8'd2);
    cyc("gera",      I_NONE, S_GER, 8'd2);
    cyc("fade",      I_NONE, S_FAD, 8'd2);
    for (int i = 0; i < 3; i++) cyc("jog3", I_NONE, S_JOG, 8'd2);
    @(negedge clock);
    @(posedge clock);
    #1;
    reset = 1'b1;
    #1;
    check("arst_st",  32'(db_estado), 32'(S_INI));
    check("arst_out", 32'(outs_v),    32'(exp_outs(S_INI)));
    check("arst_rod", 32'(rodada),    32'd0);
    cyc("rst_hold", I_NONE, S_INI, 8'd0);
    reset = 1'b0;
    cyc("post_rst", I_NONE, S_INI, 8'd0);

    // Third game: no end switch, calibration must time out.
    cyc("ini_press", I_INI, S_INI, 8'd0);
    for (int i = 0; i < T_CALIB; i++) cyc("cal_tmo", I_NONE, S_CAL, 8'd0);
    cyc("erro",    I_NONE, S_ERR, 8'd0);
    cyc("erro",    I_NONE, S_ERR, 8'd0);
    cyc("erro_go", I_INI,  S_ERR, 8'd0);
    cyc("back",    I_NONE, S_INI, 8'd0);
    @(negedge clock);
    #1;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
